// File: rtl/dm_ctrl_pkg.sv
// Shared constants, request record and byte-merge helper for the data-memory controller.
package dm_ctrl_pkg;

  localparam int AW       = 12;
  localparam int DM_WORDS = 3072;
  localparam logic [AW-1:0] DM_LIMIT = AW'(DM_WORDS);
  localparam logic [3:0]    BE_FULL  = 4'hF;

  typedef logic [1:0] dm_state_t;
  localparam dm_state_t ST_IDLE     = 2'd0;
  localparam dm_state_t ST_ACCESS   = 2'd1;
  localparam dm_state_t ST_MERGE_WR = 2'd2;
  localparam dm_state_t ST_RESP     = 2'd3;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

  typedef struct packed {
    logic          id;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   pc;
  } dm_req_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-way round-robin arbiter; the tie-break pointer flips to the other side on every grant.
module dm_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;  // requester that wins a tie

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || !ptr)) gnt[0] = 1'b1;
      else if (req[1])                 gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= 1'b0;
    else if (|gnt)  ptr <= gnt[0];
  end

endmodule

// File: rtl/dm_ctrl.sv
// CPU/DMA data-memory controller: round-robin grant, single-strobe sequencing,
// read-modify-write for partial byte enables.
module dm_ctrl
  import dm_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [3:0]    c_be,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic [31:0]   c_pc,
  output logic          c_gnt,
  output logic          c_ack,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          dm_str,
  output logic [AW-1:0] dm_A,
  output logic [31:0]   dm_D,
  output logic [31:0]   dm_pc,
  input  logic [31:0]   dm_RD
);

  dm_state_t   state;
  dm_req_t     lat, nxt;
  logic [31:0] mreg;
  logic [1:0]  gnt;
  logic        oor, partial, full_wr;

  dm_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req ({d_req, c_req}),
    .en  (state == ST_IDLE),
    .gnt (gnt)
  );

  assign c_gnt = gnt[0];
  assign d_gnt = gnt[1];

  always_comb begin
    nxt.id    = gnt[1] ? ID_DMA  : ID_CPU;
    nxt.we    = gnt[1] ? d_we    : c_we;
    nxt.be    = gnt[1] ? d_be    : c_be;
    nxt.addr  = gnt[1] ? d_addr  : c_addr;
    nxt.wdata = gnt[1] ? d_wdata : c_wdata;
    nxt.pc    = gnt[1] ? 32'h0   : c_pc;
  end

  assign oor     = lat.addr >= DM_LIMIT;
  assign full_wr = lat.we && !oor && (lat.be == BE_FULL);
  assign partial = lat.we && !oor && (lat.be != BE_FULL) && (|lat.be);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      lat     <= '0;
      mreg    <= '0;
      c_rdata <= '0;
      d_rdata <= '0;
      c_err   <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (|gnt) begin
          lat   <= nxt;
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (partial) begin
            mreg  <= dm_RD;
            state <= ST_MERGE_WR;
          end else begin
            // port-visible status only changes on the edge into the ack cycle
            state <= ST_RESP;
            if (lat.id == ID_CPU) c_err <= oor;
            else                  d_err <= oor;
            if (!oor && !lat.we) begin
              if (lat.id == ID_CPU) c_rdata <= dm_RD;
              else                  d_rdata <= dm_RD;
            end
          end
        end
        ST_MERGE_WR: begin
          state <= ST_RESP;
          if (lat.id == ID_CPU) c_err <= 1'b0;
          else                  d_err <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign c_ack  = (state == ST_RESP) && (lat.id == ID_CPU);
  assign d_ack  = (state == ST_RESP) && (lat.id == ID_DMA);
  assign dm_str = (state == ST_MERGE_WR) || ((state == ST_ACCESS) && full_wr);
  assign dm_A   = lat.addr;
  assign dm_D   = (state == ST_MERGE_WR) ? byte_merge(mreg, lat.wdata, lat.be) : lat.wdata;
  assign dm_pc  = lat.pc;

endmodule

// File: tb/tb_dm_ctrl.sv
// Self-checking bench for dm_ctrl: memory model plus scoreboard of expected acks.
module tb_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [3:0]  c_be = 0, d_be = 0;
  logic [11:0] c_addr = 0, d_addr = 0;
  logic [31:0] c_wdata = 0, d_wdata = 0, c_pc = 0;
  logic        c_gnt, c_ack, c_err, d_gnt, d_ack, d_err, dm_str;
  logic [31:0] c_rdata, d_rdata, dm_D, dm_pc, dm_RD;
  logic [11:0] dm_A;

  always #5 clk = ~clk;

  dm_ctrl dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata), .c_pc(c_pc),
    .c_gnt(c_gnt), .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .dm_str(dm_str), .dm_A(dm_A), .dm_D(dm_D), .dm_pc(dm_pc), .dm_RD(dm_RD)
  );

  logic [31:0] mem [0:3071];
  always @(posedge clk) if (dm_str && dm_A < 12'd3072) mem[dm_A] <= dm_D;
  assign dm_RD = (dm_A < 12'd3072) ? mem[dm_A] : 32'h0;

  typedef struct {
    int          port;
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } sb_t;
  sb_t q[$];

  logic [31:0] ref_mem [0:3071];
  int n_chk = 0, n_fail = 0;

  logic        sstr [0:7];
  logic [11:0] sA   [0:7];
  logic [31:0] sD   [0:7];
  logic [31:0] spc  [0:7];
  int          str_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic rq, input logic we, input logic [3:0] be,
                       input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
    if (p == 0) begin
      c_req = rq; c_we = we; c_be = be; c_addr = a; c_wdata = wd; c_pc = pc;
    end else begin
      d_req = rq; d_we = we; d_be = be; d_addr = a; d_wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? c_gnt : d_gnt;
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 0) ? c_ack : d_ack;
  endfunction

  // Pushes the expected ack for one op and updates the reference memory.
  task automatic expect_op(input int p, input logic we, input logic [3:0] be,
                           input logic [11:0] a, input logic [31:0] wd);
    sb_t e;
    e.port   = p;
    e.err    = (a >= 12'd3072);
    e.chk_rd = !we && !e.err;
    e.rd     = e.chk_rd ? ref_mem[a] : 32'h0;
    if (we && !e.err)
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
    q.push_back(e);
  endtask

  task automatic do_op(input int p, input logic we, input logic [3:0] be,
                       input logic [11:0] a, input logic [31:0] wd, input logic [31:0] pc);
    int exp_lat, got, w;
    exp_lat = (we && a < 12'd3072 && be != 4'h0 && be != 4'hF) ? 3 : 2;
    expect_op(p, we, be, a, wd);
    @(negedge clk);
    drive(p, 1'b1, we, be, a, wd, pc);
    #1;
    w = 0;
    while (!gnt_of(p) && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!gnt_of(p)) begin
      chk("gnt_timeout", 32'd0, 32'd1);
      drive(p, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
      return;
    end
    got = 7; str_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
      if (k == 1) drive(p, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
      sstr[k] = dm_str; sA[k] = dm_A; sD[k] = dm_D; spc[k] = dm_pc;
      if (dm_str) str_cnt++;
      if (ack_of(p)) begin got = k; break; end
    end
    chk("latency", got, exp_lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    #1;
    if (c_ack || d_ack) begin
      if (q.size() == 0) chk("sb_unexpected_ack", {30'd0, c_ack, d_ack}, 32'd0);
      else begin
        sb_t e;
        e = q.pop_front();
        chk("sb_port", {30'd0, c_ack, d_ack}, (e.port == 0) ? 32'd2 : 32'd1);
        if (e.chk_rd) chk("sb_rdata", (e.port == 0) ? c_rdata : d_rdata, e.rd);
        chk("sb_err", {31'd0, (e.port == 0) ? c_err : d_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    int ngr, last, cg, dg;
    logic [11:0] addrs [0:2];
    for (int i = 0; i < 3072; i++) ref_mem[i] = 32'h0;
    addrs[0] = 12'h004; addrs[1] = 12'h010; addrs[2] = 12'hBFF;

    do_reset();
    #1;
    chk("rst_c_gnt", {31'd0, c_gnt}, 0);
    chk("rst_acks", {30'd0, c_ack, d_ack}, 0);
    chk("rst_errs", {30'd0, c_err, d_err}, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_dm_str", {31'd0, dm_str}, 0);
    chk("rst_dm_A", {20'd0, dm_A}, 0);
    chk("rst_dm_D", dm_D, 0);
    chk("rst_dm_pc", dm_pc, 0);

    do_op(0, 1'b1, 4'hF, 12'h004, 32'hDEADBEEF, 32'h3000);
    chk("fw_str", {31'd0, sstr[1]}, 1);
    chk("fw_A", {20'd0, sA[1]}, 32'h004);
    chk("fw_D", sD[1], 32'hDEADBEEF);
    chk("fw_pc", spc[1], 32'h3000);

    do_op(1, 1'b1, 4'b0011, 12'h004, 32'h00001234, 32'h0);
    chk("pw_access_nostr", {31'd0, sstr[1]}, 0);
    chk("pw_merge_str", {31'd0, sstr[2]}, 1);
    chk("pw_merge_A", {20'd0, sA[2]}, 32'h004);
    chk("pw_merge_D", sD[2], 32'hDEAD1234);
    chk("pw_dma_pc", spc[2], 0);
    do_op(1, 1'b0, 4'h0, 12'h004, 32'h0, 32'h0);
    chk("rd_nostr", str_cnt, 0);

    do_op(0, 1'b0, 4'h0, 12'hC00, 32'h0, 32'h4000);
    chk("oor_rd_nostr", str_cnt, 0);
    do_op(0, 1'b1, 4'hF, 12'hC00, 32'h55555555, 32'h4004);
    chk("oor_wr_nostr", str_cnt, 0);

    do_op(1, 1'b1, 4'h0, 12'h004, 32'hFFFFFFFF, 32'h0);
    chk("null_wr_nostr", str_cnt, 0);
    do_op(0, 1'b0, 4'h0, 12'h004, 32'h0, 32'h5000);

    do_op(0, 1'b1, 4'hF, 12'hBFF, 32'hCAFEF00D, 32'h5004);
    do_op(1, 1'b0, 4'h0, 12'hBFF, 32'h0, 32'h0);
    do_op(0, 1'b1, 4'b1000, 12'h004, 32'hAA000000, 32'h5008);
    do_op(0, 1'b0, 4'h0, 12'h004, 32'h0, 32'h500C);
    do_op(0, 1'b1, 4'hF, 12'h010, 32'h11223344, 32'h5010);

    // Both requesters held: grants must alternate, one every three cycles.
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 4'h0, 12'h004, 32'h0, 32'h6000);
    drive(1, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) expect_op(i % 2, 1'b0, 4'h0, (i % 2 == 0) ? 12'h004 : 12'h010, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ngr = 0; last = 0;
    for (int cyc = 0; cyc < 40 && ngr < 4; cyc++) begin
      #1;
      if (c_gnt || d_gnt) begin
        chk("alt_gnt", {30'd0, c_gnt, d_gnt}, (ngr % 2 == 0) ? 32'd2 : 32'd1);
        if (ngr > 0) chk("alt_gap", cyc - last, 3);
        last = cyc; ngr++;
      end
      @(negedge clk);
    end
    drive(0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
    chk("alt_count", ngr, 4);
    repeat (4) @(negedge clk);

    // Reset during the merge write must abort it with no strobe and no ack.
    drive(1, 1'b1, 1'b1, 4'b0011, 12'h010, 32'h0000ABCD, 32'h0);
    #1;
    for (int w = 0; w < 20 && !d_gnt; w++) begin @(negedge clk); #1; end
    chk("mr_gnt", {31'd0, d_gnt}, 1);
    @(negedge clk); #1;
    drive(1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("mr_merge_str", {31'd0, dm_str}, 1);
    rst = 1'b1;
    #1;
    chk("mr_rst_str", {31'd0, dm_str}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("mr_mem_kept", mem[12'h010], 32'h11223344);
    chk("mr_no_ack", {30'd0, c_ack, d_ack}, 0);
    expect_op(0, 1'b0, 4'h0, 12'h010, 32'h0);
    expect_op(1, 1'b0, 4'h0, 12'h010, 32'h0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 32'h7000);
    drive(1, 1'b1, 1'b0, 4'h0, 12'h010, 32'h0, 32'h0);
    #1;
    chk("mr_cpu_wins", {30'd0, c_gnt, d_gnt}, 2);
    cg = c_gnt; dg = d_gnt;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
      if (cg != 0) c_req = 1'b0;
      if (dg != 0) d_req = 1'b0;
      #1;
      cg = c_gnt; dg = d_gnt;
    end
    drive(0, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      logic [11:0] a;
      a = addrs[$urandom_range(0, 2)];
      do_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, $urandom);
    end
    for (int i = 0; i < 3; i++) do_op(i % 2, 1'b0, 4'h0, addrs[i], 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
